// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Central stall/flush sequencer for the 5-stage pipeline. Combines load-use
//   hazard flags from the rs1/rs2 operand forwarders, the EX-stage redirect and
//   the MEM-stage data-memory handshake into per-stage stall, ID flush and EX
//   bubble controls. Also keeps saturating stall/flush cycle counters and a
//   sticky data-memory timeout flag.
//
// Ports
//   clk_i            core clock, rising edge
//   rst_ni           asynchronous active-low reset
//   lu_hazard_rs1_i  load-use hazard from the rs1 forwarder
//   lu_hazard_rs2_i  load-use hazard from the rs2 forwarder
//   ex_redirect_i    taken branch/jump resolved in EX this cycle
//   mem_req_i        MEM holds a load/store issued to dmem this cycle
//   mem_ack_i        dmem completes the MEM access this cycle
//   if_stall_o       hold PC and IF/ID
//   id_stall_o       hold ID/EX inputs
//   ex_stall_o       hold EX/MEM
//   mem_stall_o      hold MEM/WB
//   id_flush_o       invalidate IF/ID on the next edge
//   ex_bubble_o      load a NOP into ID/EX on the next edge
//   mem_timeout_o    sticky: dmem did not answer within TIMEOUT_CYC cycles
//   stall_cnt_o      saturating count of cycles with if_stall_o=1
//   flush_cnt_o      saturating count of cycles with id_flush_o=1
//   dbg_state_o      current FSM state (RUN=0, MEM_WAIT=1, TIMEOUT=2)
//
// Memory handshake: mem_req_i marks a dmem access held in MEM; the access
// completes in the first cycle where mem_req_i and mem_ack_i are both high
// (the request cycle itself or any later MEM_WAIT cycle). An ack without a
// request in RUN carries no meaning and is ignored.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT_CYC = 256,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             lu_hazard_rs1_i,
  input  logic             lu_hazard_rs2_i,
  input  logic             ex_redirect_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             if_stall_o,
  output logic             id_stall_o,
  output logic             ex_stall_o,
  output logic             mem_stall_o,
  output logic             id_flush_o,
  output logic             ex_bubble_o,
  output logic             mem_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } state_e;

  // Wide enough to hold TIMEOUT_CYC itself; the counter never exceeds it.
  localparam int WAIT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(TIMEOUT_CYC);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]    stall_cnt_q, flush_cnt_q;

  logic if_stall, id_stall, ex_stall, mem_stall, id_flush, ex_bubble;
  logic lu_hazard;

  assign lu_hazard = lu_hazard_rs1_i | lu_hazard_rs2_i;

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    if_stall  = 1'b0;
    id_stall  = 1'b0;
    ex_stall  = 1'b0;
    mem_stall = 1'b0;
    id_flush  = 1'b0;
    ex_bubble = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_req_i && !mem_ack_i) begin
          {if_stall, id_stall, ex_stall, mem_stall} = 4'b1111;
          state_d = MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end else if (ex_redirect_i) begin
          // Squash the ID instruction; any load-use flag belongs to it.
          id_flush  = 1'b1;
          ex_bubble = 1'b1;
        end else if (lu_hazard) begin
          // Hold IF/ID, let the load move on to MEM behind a bubble.
          if_stall  = 1'b1;
          id_stall  = 1'b1;
          ex_bubble = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_ack_i) begin
          // Access retires; the frozen EX/ID hazards are serviced now.
          state_d = RUN;
          wait_d  = '0;
          if (ex_redirect_i) begin
            id_flush  = 1'b1;
            ex_bubble = 1'b1;
          end else if (lu_hazard) begin
            if_stall  = 1'b1;
            id_stall  = 1'b1;
            ex_bubble = 1'b1;
          end
        end else begin
          {if_stall, id_stall, ex_stall, mem_stall} = 4'b1111;
          if (TIMEOUT_CYC != 0) begin
            if (wait_q >= WAIT_LIM) state_d = TIMEOUT;
            else                    wait_d  = wait_q + WAIT_W'(1);
          end
        end
      end
      TIMEOUT: begin
        {if_stall, id_stall, ex_stall, mem_stall} = 4'b1111;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Controls are forced low while reset is asserted, independent of the clock.
  assign if_stall_o  = if_stall  & rst_ni;
  assign id_stall_o  = id_stall  & rst_ni;
  assign ex_stall_o  = ex_stall  & rst_ni;
  assign mem_stall_o = mem_stall & rst_ni;
  assign id_flush_o  = id_flush  & rst_ni;
  assign ex_bubble_o = ex_bubble & rst_ni;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RUN;
      wait_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (if_stall_o && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (id_flush_o && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign mem_timeout_o = (state_q == TIMEOUT);
  assign stall_cnt_o   = stall_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W    = 3;
  localparam int TO_CYC   = 4;
  localparam int NT_CNT_W = 8;

  // {if, id, ex, mem, flush, bubble}
  localparam logic [5:0] C_NONE  = 6'b000000;
  localparam logic [5:0] C_ALL   = 6'b111100;
  localparam logic [5:0] C_FLUSH = 6'b000011;
  localparam logic [5:0] C_LU    = 6'b110001;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic lu_hazard_rs1_i = 1'b0, lu_hazard_rs2_i = 1'b0, ex_redirect_i = 1'b0;
  logic mem_req_i = 1'b0, mem_ack_i = 1'b0;

  logic if_stall_o, id_stall_o, ex_stall_o, mem_stall_o, id_flush_o, ex_bubble_o;
  logic mem_timeout_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;
  logic [1:0] dbg_state_o;

  logic nt_if_stall, nt_id_stall, nt_ex_stall, nt_mem_stall, nt_id_flush, nt_ex_bubble;
  logic nt_timeout;
  logic [NT_CNT_W-1:0] nt_stall_cnt, nt_flush_cnt;
  logic [1:0] nt_state;

  logic [5:0] ctrl, nt_ctrl;
  assign ctrl    = {if_stall_o, id_stall_o, ex_stall_o, mem_stall_o, id_flush_o, ex_bubble_o};
  assign nt_ctrl = {nt_if_stall, nt_id_stall, nt_ex_stall, nt_mem_stall, nt_id_flush, nt_ex_bubble};

  pipeline_hazard_ctrl #(.TIMEOUT_CYC(TO_CYC), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .lu_hazard_rs1_i(lu_hazard_rs1_i), .lu_hazard_rs2_i(lu_hazard_rs2_i),
    .ex_redirect_i(ex_redirect_i), .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
    .if_stall_o(if_stall_o), .id_stall_o(id_stall_o), .ex_stall_o(ex_stall_o),
    .mem_stall_o(mem_stall_o), .id_flush_o(id_flush_o), .ex_bubble_o(ex_bubble_o),
    .mem_timeout_o(mem_timeout_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o),
    .dbg_state_o(dbg_state_o)
  );

  // Second instance with the timeout disabled and wider counters.
  pipeline_hazard_ctrl #(.TIMEOUT_CYC(0), .CNT_W(NT_CNT_W)) dut_nt (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .lu_hazard_rs1_i(lu_hazard_rs1_i), .lu_hazard_rs2_i(lu_hazard_rs2_i),
    .ex_redirect_i(ex_redirect_i), .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
    .if_stall_o(nt_if_stall), .id_stall_o(nt_id_stall), .ex_stall_o(nt_ex_stall),
    .mem_stall_o(nt_mem_stall), .id_flush_o(nt_id_flush), .ex_bubble_o(nt_ex_bubble),
    .mem_timeout_o(nt_timeout), .stall_cnt_o(nt_stall_cnt), .flush_cnt_o(nt_flush_cnt),
    .dbg_state_o(nt_state)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  logic [5:0] exp_q[$];

  // Driver: drive one cycle of inputs at the falling edge, queue the expected
  // controls, then pop and compare once the combinational outputs settle.
  task automatic drive(input logic req, input logic ack, input logic redir,
                       input logic rs1, input logic rs2, input logic [5:0] exp,
                       input string name);
    logic [5:0] e;
    @(negedge clk_i);
    mem_req_i = req; mem_ack_i = ack; ex_redirect_i = redir;
    lu_hazard_rs1_i = rs1; lu_hazard_rs2_i = rs2;
    exp_q.push_back(exp);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (ctrl !== e) begin
      errors++;
      $display("FAIL %s: ctrl={if,id,ex,mem,flush,bubble} got %b expected %b", name, ctrl, e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    mem_req_i = 0; mem_ack_i = 0; ex_redirect_i = 0; lu_hazard_rs1_i = 0; lu_hazard_rs2_i = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    mem_req_i = 1; ex_redirect_i = 1; lu_hazard_rs1_i = 1;
    #1;
    checks++;
    if (ctrl !== C_NONE) begin errors++; $display("FAIL reset_ctrl: got %b expected %b", ctrl, C_NONE); end
    checks++;
    if (stall_cnt_o !== 3'd0 || flush_cnt_o !== 3'd0) begin
      errors++; $display("FAIL reset_cnt: stall=%0d flush=%0d expected 0/0", stall_cnt_o, flush_cnt_o);
    end
    checks++;
    if (mem_timeout_o !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", mem_timeout_o); end
    do_reset();
  endtask

  task automatic test_lu_hazard();
    do_reset();
    drive(0, 0, 0, 1, 0, C_LU, "rs1_hazard");
    drive(0, 0, 0, 0, 0, C_NONE, "rs1_hazard_after");
    checks++;
    if (stall_cnt_o !== 3'd1) begin errors++; $display("FAIL rs1_stall_cnt: got %0d expected 1", stall_cnt_o); end
    drive(0, 0, 0, 0, 1, C_LU, "rs2_hazard");
    drive(0, 1, 0, 0, 0, C_NONE, "ack_without_req");
    checks++;
    if (stall_cnt_o !== 3'd2 || flush_cnt_o !== 3'd0) begin
      errors++; $display("FAIL lu_cnts: stall=%0d flush=%0d expected 2/0", stall_cnt_o, flush_cnt_o);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    drive(1, 0, 0, 0, 0, C_ALL, "mem_req");
    drive(1, 0, 0, 0, 0, C_ALL, "mem_wait1");
    drive(1, 0, 0, 0, 0, C_ALL, "mem_wait2");
    drive(1, 1, 0, 0, 0, C_NONE, "mem_ack");
    drive(0, 0, 0, 0, 0, C_NONE, "mem_back_to_run");
    checks++;
    if (stall_cnt_o !== 3'd3) begin errors++; $display("FAIL mem_stall_cnt: got %0d expected 3", stall_cnt_o); end
    // Zero-wait access never enters MEM_WAIT.
    drive(1, 1, 0, 0, 0, C_NONE, "zero_wait");
    drive(0, 0, 0, 0, 0, C_NONE, "zero_wait_idle");
    checks++;
    if (stall_cnt_o !== 3'd3) begin errors++; $display("FAIL zero_wait_cnt: got %0d expected 3", stall_cnt_o); end
  endtask

  task automatic test_redirect();
    do_reset();
    drive(0, 0, 1, 0, 1, C_FLUSH, "redirect_rs2");
    drive(0, 0, 0, 0, 0, C_NONE, "redirect_after");
    checks++;
    if (flush_cnt_o !== 3'd1 || stall_cnt_o !== 3'd0) begin
      errors++; $display("FAIL redirect_cnts: flush=%0d stall=%0d expected 1/0", flush_cnt_o, stall_cnt_o);
    end
    // Redirect held during MEM_WAIT is serviced on the ack cycle.
    do_reset();
    drive(1, 0, 0, 0, 0, C_ALL, "wait_redir_req");
    drive(1, 0, 1, 0, 0, C_ALL, "wait_redir_hold1");
    drive(1, 0, 1, 0, 0, C_ALL, "wait_redir_hold2");
    drive(1, 1, 1, 1, 0, C_FLUSH, "wait_redir_ack");
    drive(0, 0, 0, 0, 0, C_NONE, "wait_redir_idle");
    checks++;
    if (flush_cnt_o !== 3'd1 || stall_cnt_o !== 3'd3) begin
      errors++; $display("FAIL wait_redir_cnts: flush=%0d stall=%0d expected 1/3", flush_cnt_o, stall_cnt_o);
    end
    // Load-use hazard on the ack cycle.
    drive(1, 0, 0, 0, 0, C_ALL, "wait_lu_req");
    drive(1, 1, 0, 0, 1, C_LU, "wait_lu_ack");
    drive(0, 0, 0, 0, 0, C_NONE, "wait_lu_idle");
  endtask

  task automatic test_timeout();
    do_reset();
    drive(1, 0, 0, 0, 0, C_ALL, "to_req");
    for (int i = 1; i <= TO_CYC; i++) drive(1, 0, 0, 0, 0, C_ALL, "to_wait");
    checks++;
    if (mem_timeout_o !== 1'b0) begin errors++; $display("FAIL to_early: got %b expected 0", mem_timeout_o); end
    drive(1, 1, 1, 0, 0, C_ALL, "to_ack_ignored");
    checks++;
    if (mem_timeout_o !== 1'b1) begin errors++; $display("FAIL to_flag: got %b expected 1", mem_timeout_o); end
    checks++;
    if (nt_timeout !== 1'b0 || nt_ctrl !== C_FLUSH) begin
      errors++; $display("FAIL nt_no_timeout: timeout=%b ctrl=%b expected 0/%b", nt_timeout, nt_ctrl, C_FLUSH);
    end
    drive(0, 0, 0, 0, 0, C_ALL, "to_stuck");
    checks++;
    if (mem_timeout_o !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", mem_timeout_o); end
    // Asynchronous reset clears controls at once, then state.
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    checks++;
    if (ctrl !== C_NONE || mem_timeout_o !== 1'b0 || stall_cnt_o !== 3'd0) begin
      errors++; $display("FAIL to_reset: ctrl=%b timeout=%b stall=%0d expected %b/0/0", ctrl, mem_timeout_o, stall_cnt_o, C_NONE);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(0, 0, 0, 0, 0, C_NONE, "to_after_reset");
    // Ack on the limit cycle wins.
    do_reset();
    drive(1, 0, 0, 0, 0, C_ALL, "lim_req");
    for (int i = 1; i < TO_CYC; i++) drive(1, 0, 0, 0, 0, C_ALL, "lim_wait");
    drive(1, 1, 0, 0, 0, C_NONE, "lim_ack");
    drive(0, 0, 0, 0, 0, C_NONE, "lim_run");
    checks++;
    if (mem_timeout_o !== 1'b0) begin errors++; $display("FAIL lim_no_timeout: got %b expected 0", mem_timeout_o); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 10; i++) drive(0, 0, 0, 1, 1, C_LU, "sat_lu");
    drive(0, 0, 0, 0, 0, C_NONE, "sat_idle");
    drive(0, 0, 0, 0, 0, C_NONE, "sat_idle2");
    checks++;
    if (stall_cnt_o !== 3'd7) begin errors++; $display("FAIL stall_sat: got %0d expected 7", stall_cnt_o); end
    checks++;
    if (nt_stall_cnt !== 8'd10) begin errors++; $display("FAIL nt_stall_cnt: got %0d expected 10", nt_stall_cnt); end
    for (int i = 0; i < 9; i++) drive(0, 0, 1, 0, 0, C_FLUSH, "sat_flush");
    drive(0, 0, 0, 0, 0, C_NONE, "sat_flush_idle");
    checks++;
    if (flush_cnt_o !== 3'd7) begin errors++; $display("FAIL flush_sat: got %0d expected 7", flush_cnt_o); end
  endtask

  task automatic test_random_run();
    int m_stall, m_flush;
    logic redir, rs1, rs2, ack;
    logic [5:0] e;
    logic [CNT_W-1:0] es, ef;
    do_reset();
    m_stall = 0; m_flush = 0;
    for (int i = 0; i < 40; i++) begin
      redir = 1'($urandom_range(0, 3) == 0);
      rs1   = 1'($urandom_range(0, 2) == 0);
      rs2   = 1'($urandom_range(0, 2) == 0);
      ack   = 1'($urandom_range(0, 1));
      if (redir) begin e = C_FLUSH; m_flush++; end
      else if (rs1 | rs2) begin e = C_LU; m_stall++; end
      else e = C_NONE;
      drive(0, ack, redir, rs1, rs2, e, "rand_run");
    end
    drive(0, 0, 0, 0, 0, C_NONE, "rand_idle");
    es = (m_stall > 7) ? 3'd7 : 3'(m_stall);
    ef = (m_flush > 7) ? 3'd7 : 3'(m_flush);
    checks++;
    if (stall_cnt_o !== es || flush_cnt_o !== ef) begin
      errors++; $display("FAIL rand_cnts: stall=%0d flush=%0d expected %0d/%0d", stall_cnt_o, flush_cnt_o, es, ef);
    end
    checks++;
    if (nt_stall_cnt !== 8'(m_stall) || nt_flush_cnt !== 8'(m_flush)) begin
      errors++; $display("FAIL rand_nt_cnts: stall=%0d flush=%0d expected %0d/%0d", nt_stall_cnt, nt_flush_cnt, m_stall, m_flush);
    end
  endtask

  initial begin
    test_reset();
    test_lu_hazard();
    test_mem_wait();
    test_redirect();
    test_timeout();
    test_saturation();
    test_random_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
